// File: rtl/fmap_buf.sv
// fmap_buf: feature-map buffer. Fills a MAP_H x MAP_W pixel map in row-major
// order, then drains it as column beats of WIN_ROWS-row windows stepped by
// STRIDE rows. Optional macro FMAP_BUF_ERR_EN adds a sticky protocol error
// output err_o.
`timescale 1ns/1ps

module fmap_buf #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned MAP_W    = 12,
  parameter int unsigned MAP_H    = 12,
  parameter int unsigned WIN_ROWS = 6,
  parameter int unsigned STRIDE   = 2
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         clear_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [DATA_W-1:0]            wr_data_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [WIN_ROWS*DATA_W-1:0]   rd_data_o,
  output logic [$clog2(MAP_W)-1:0]     rd_col_o,
  output logic                         rd_last_o
`ifdef FMAP_BUF_ERR_EN
  ,
  output logic                         err_o
`endif
);

  localparam int unsigned COL_W    = $clog2(MAP_W);
  localparam int unsigned ROW_W    = $clog2(MAP_H);
  localparam int unsigned NWIN     = (MAP_H - WIN_ROWS) / STRIDE + 1;
  localparam int unsigned LAST_OFF = (NWIN - 1) * STRIDE;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ROW_W-1:0]   r_wr_row, w_wr_row_nxt;
  logic [COL_W-1:0]   r_wr_col, w_wr_col_nxt;
  logic [COL_W-1:0]   r_col, w_col_nxt;
  logic [ROW_W-1:0]   r_row_off, w_row_off_nxt;
  logic               w_wr_en;
  logic               w_last;
  logic [WIN_ROWS*DATA_W-1:0] w_rd_data;

  // Pixel storage; deliberately not reset, only the control state is.
  logic [DATA_W-1:0]  r_mem [MAP_H][MAP_W];

  assign w_last = (r_state == S_DRAIN) &&
                  (r_row_off == ROW_W'(LAST_OFF)) &&
                  (r_col == COL_W'(MAP_W - 1));

  // Next-state and counter update; clear_i overrides any handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_row_nxt  = r_wr_row;
    w_wr_col_nxt  = r_wr_col;
    w_col_nxt     = r_col;
    w_row_off_nxt = r_row_off;
    w_wr_en       = 1'b0;
    if (clear_i) begin
      w_state_nxt   = S_FILL;
      w_wr_row_nxt  = '0;
      w_wr_col_nxt  = '0;
      w_col_nxt     = '0;
      w_row_off_nxt = '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (wr_valid_i) begin
            w_wr_en = 1'b1;
            if (r_wr_col == COL_W'(MAP_W - 1)) begin
              w_wr_col_nxt = '0;
              if (r_wr_row == ROW_W'(MAP_H - 1)) begin
                w_wr_row_nxt = '0;
                w_state_nxt  = S_DRAIN;
              end else begin
                w_wr_row_nxt = r_wr_row + ROW_W'(1);
              end
            end else begin
              w_wr_col_nxt = r_wr_col + COL_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (rd_ready_i) begin
            if (w_last) begin
              w_state_nxt   = S_FILL;
              w_col_nxt     = '0;
              w_row_off_nxt = '0;
            end else if (r_col == COL_W'(MAP_W - 1)) begin
              w_col_nxt     = '0;
              w_row_off_nxt = r_row_off + ROW_W'(STRIDE);
            end else begin
              w_col_nxt = r_col + COL_W'(1);
            end
          end
        end
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= S_FILL;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_col     <= '0;
      r_row_off <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_row  <= w_wr_row_nxt;
      r_wr_col  <= w_wr_col_nxt;
      r_col     <= w_col_nxt;
      r_row_off <= w_row_off_nxt;
    end
  end

  // Pixel write port.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr_row][r_wr_col] <= wr_data_i;
  end

  // Window column gather: lane i holds row row_off+i of the current column.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < int'(WIN_ROWS); i++) begin
      w_rd_data[i*DATA_W +: DATA_W] = r_mem[r_row_off + ROW_W'(i)][r_col];
    end
  end

  assign wr_ready_o = (r_state == S_FILL);
  assign rd_valid_o = (r_state == S_DRAIN);
  assign rd_data_o  = w_rd_data;
  assign rd_col_o   = r_col;
  assign rd_last_o  = w_last;

`ifdef FMAP_BUF_ERR_EN
  logic r_err;
  logic w_err_nxt;

  // Sticky flag for writes offered while draining or reads offered while filling.
  always_comb begin
    w_err_nxt = r_err;
    if (clear_i) begin
      w_err_nxt = 1'b0;
    end else if ((r_state == S_DRAIN && wr_valid_i) ||
                 (r_state == S_FILL && rd_ready_i)) begin
      w_err_nxt = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_err <= 1'b0;
    else         r_err <= w_err_nxt;
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_fmap_buf.sv
// tb_fmap_buf: directed + randomized bench for fmap_buf against an array model
// of the stored map. Checks for err_o are included when FMAP_BUF_ERR_EN is set.
`timescale 1ns/1ps

module tb_fmap_buf;

  localparam int DW   = 12;
  localparam int MW   = 12;
  localparam int MH   = 12;
  localparam int WR   = 6;
  localparam int ST   = 2;
  localparam int NWIN = (MH - WR) / ST + 1;
  localparam int NB   = NWIN * MW;

  localparam int MW2  = 5;
  localparam int MH2  = 7;
  localparam int WR2  = 3;
  localparam int ST2  = 3;

  logic clk;
  logic rstn;
  logic clear;

  logic              wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
  logic [DW-1:0]     wr_data;
  logic [WR*DW-1:0]  rd_data;
  logic [3:0]        rd_col;

  logic              wr_valid2, wr_ready2, rd_valid2, rd_ready2, rd_last2;
  logic [DW-1:0]     wr_data2;
  logic [WR2*DW-1:0] rd_data2;
  logic [2:0]        rd_col2;

`ifdef FMAP_BUF_ERR_EN
  logic err_o, err_o2;
`endif

  int n_chk;
  int n_err;
  int img  [MH][MW];
  int img2 [MH2][MW2];

  fmap_buf #(.DATA_W(DW), .MAP_W(MW), .MAP_H(MH), .WIN_ROWS(WR), .STRIDE(ST)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .rd_col_o(rd_col), .rd_last_o(rd_last)
`ifdef FMAP_BUF_ERR_EN
    , .err_o(err_o)
`endif
  );

  fmap_buf #(.DATA_W(DW), .MAP_W(MW2), .MAP_H(MH2), .WIN_ROWS(WR2), .STRIDE(ST2)) u_dut2 (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear),
    .wr_valid_i(wr_valid2), .wr_ready_o(wr_ready2), .wr_data_i(wr_data2),
    .rd_valid_o(rd_valid2), .rd_ready_i(rd_ready2), .rd_data_o(rd_data2),
    .rd_col_o(rd_col2), .rd_last_o(rd_last2)
`ifdef FMAP_BUF_ERR_EN
    , .err_o(err_o2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat: window beat/MW starts at row (beat/MW)*ST, column beat%MW.
  function automatic logic [WR*DW-1:0] exp_lanes(input int beat);
    logic [WR*DW-1:0] v;
    int w, c;
    w = beat / MW;
    c = beat % MW;
    for (int i = 0; i < WR; i++) v[i*DW +: DW] = DW'(img[w*ST + i][c]);
    return v;
  endfunction

  // mode 0: pixel = index, 1: base + index, 2: random signed. Called at a negedge.
  task automatic fill_map(input int mode, input int base, input int nwr);
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < MW; c++)
        img[r][c] = (mode == 0) ? r*MW + c :
                    (mode == 1) ? base + r*MW + c :
                    int'($urandom_range(0, 4095)) - 2048;
    for (int k = 0; k < nwr; k++) begin
      check("fill_wr_ready", wr_ready, 1'b1);
      check("fill_rd_valid", rd_valid, 1'b0);
      wr_valid = 1'b1;
      wr_data  = DW'(img[k / MW][k % MW]);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    if (nwr == MH*MW) begin
      check("fill_done_rd_valid", rd_valid, 1'b1);
      check("fill_done_wr_ready", wr_ready, 1'b0);
    end
  endtask

  // rmode 0: always ready, 1: toggle, 2: random. stop_kind 0: clear, 1: reset.
  task automatic drain(input int rmode, input int stop_at, input int stop_kind, input int inject_at);
    int beat = 0;
    int cyc  = 0;
    bit rdy  = 1'b1;
    bit injected = 1'b0;
    while (beat < NB && cyc < 8*NB) begin
      check("drain_rd_valid", rd_valid, 1'b1);
      check("drain_data", rd_data, exp_lanes(beat));
      check("drain_col", rd_col, beat % MW);
      check("drain_last", rd_last, beat == NB-1);
`ifdef FMAP_BUF_ERR_EN
      check("drain_err", err_o, injected);
`endif
      if (beat == stop_at) begin
        rd_ready = 1'b1;
        if (stop_kind == 0) begin
          clear = 1'b1;
          @(negedge clk);
          clear = 1'b0;
        end else begin
          #2 rstn = 1'b0;
          #1;
        end
        check("stop_wr_ready", wr_ready, 1'b1);
        check("stop_rd_valid", rd_valid, 1'b0);
        check("stop_rd_col", rd_col, 0);
        check("stop_rd_last", rd_last, 1'b0);
`ifdef FMAP_BUF_ERR_EN
        check("stop_err", err_o, 1'b0);
`endif
        if (stop_kind != 0) begin
          @(negedge clk);
          rstn = 1'b1;
        end
        rd_ready = 1'b0;
        return;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rd_ready = rdy;
      if (beat == inject_at && !injected) begin
        wr_valid = 1'b1;
        wr_data  = DW'($urandom);
        injected = 1'b1;
      end
      @(negedge clk);
      wr_valid = 1'b0;
      if (rdy) beat++;
      cyc++;
    end
    rd_ready = 1'b0;
    check("drain_beats", beat, NB);
    check("drain_end_wr_ready", wr_ready, 1'b1);
    check("drain_end_rd_valid", rd_valid, 1'b0);
    check("drain_end_rd_last", rd_last, 1'b0);
    check("drain_end_rd_col", rd_col, 0);
  endtask

  // Small-geometry instance: 5x7 map, 3-row windows at stride 3 -> rows 0..5 only.
  task automatic fill_drain2();
    logic [WR2*DW-1:0] ev;
    int beat = 0;
    int cyc  = 0;
    int w, c;
    for (int r = 0; r < MH2; r++)
      for (int cc = 0; cc < MW2; cc++)
        img2[r][cc] = int'($urandom_range(0, 4095));
    for (int k = 0; k < MH2*MW2; k++) begin
      check("fill2_wr_ready", wr_ready2, 1'b1);
      wr_valid2 = 1'b1;
      wr_data2  = DW'(img2[k / MW2][k % MW2]);
      @(negedge clk);
    end
    wr_valid2 = 1'b0;
    check("fill2_done_rd_valid", rd_valid2, 1'b1);
    while (beat < 10 && cyc < 100) begin
      w = beat / MW2;
      c = beat % MW2;
      for (int i = 0; i < WR2; i++) ev[i*DW +: DW] = DW'(img2[w*ST2 + i][c]);
      check("drain2_rd_valid", rd_valid2, 1'b1);
      check("drain2_data", rd_data2, ev);
      check("drain2_col", rd_col2, c);
      check("drain2_last", rd_last2, beat == 9);
      rd_ready2 = 1'b1;
      @(negedge clk);
      beat++;
      cyc++;
    end
    rd_ready2 = 1'b0;
    check("drain2_beats", beat, 10);
    check("drain2_end_wr_ready", wr_ready2, 1'b1);
    check("drain2_end_rd_valid", rd_valid2, 1'b0);
  endtask

  initial begin
    logic [WR*DW-1:0] v;
    n_chk = 0;
    n_err = 0;
    rstn = 1'b0; clear = 1'b0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    wr_valid2 = 1'b0; wr_data2 = '0; rd_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_last", rd_last, 1'b0);
    check("rst_rd_col", rd_col, 0);
    check("rst_wr_ready2", wr_ready2, 1'b1);
    check("rst_rd_valid2", rd_valid2, 1'b0);
`ifdef FMAP_BUF_ERR_EN
    check("rst_err", err_o, 1'b0);
`endif
    rstn = 1'b1;
    @(negedge clk);

    // Index map, always ready; first beat lanes are 0,12,...,60.
    fill_map(0, 0, MH*MW);
    v = {12'd60, 12'd48, 12'd36, 12'd24, 12'd12, 12'd0};
    check("beat0_index", rd_data, v);
    drain(0, -1, 0, -1);

    // Same map, consumer toggles ready every cycle.
    fill_map(0, 0, MH*MW);
    drain(1, -1, 0, -1);

    // Random map, stray write during drain, clear at beat 20.
    fill_map(2, 0, MH*MW);
    drain(2, 20, 0, 10);

    // Refill with 1000+k after clear.
    fill_map(1, 1000, MH*MW);
    v = {12'd1060, 12'd1048, 12'd1036, 12'd1024, 12'd1012, 12'd1000};
    check("beat0_refill", rd_data, v);
    drain(2, -1, 0, -1);

    // Reset after 70 writes.
    fill_map(2, 0, 70);
    #2 rstn = 1'b0;
    #1;
    check("midfill_rst_wr_ready", wr_ready, 1'b1);
    check("midfill_rst_rd_valid", rd_valid, 1'b0);
    check("midfill_rst_rd_col", rd_col, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Fresh map after reset, then reset while the last beat is presented.
    fill_map(2, 0, MH*MW);
    drain(0, NB-1, 1, -1);
    @(negedge clk);

    // Fresh map after mid-drain reset drains in full.
    fill_map(2, 0, MH*MW);
    drain(2, -1, 0, -1);

    fill_drain2();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fmap_buf.md
FMAP_BUF -- requirements
Module: fmap_buf

Interface
REQ-001 Parameter DATA_W, default 12, pixel width in bits (signed two's complement).
REQ-002 Parameter MAP_W, default 12, feature-map columns.
REQ-003 Parameter MAP_H, default 12, feature-map rows.
REQ-004 Parameter WIN_ROWS, default 6, rows emitted per read beat; SHALL satisfy 1 <= WIN_ROWS <= MAP_H.
REQ-005 Parameter STRIDE, default 2, row step between windows; SHALL be >= 1.
REQ-006 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 rstn_i  input  1  reset, asynchronous, active-low.
REQ-008 clear_i  input  1  synchronous abort; returns block to FILL.
REQ-009 wr_valid_i  input  1  write pixel offered.
REQ-010 wr_ready_o  output  1  write pixel accepted when wr_valid_i & wr_ready_o.
REQ-011 wr_data_i  input  DATA_W  pixel, row-major order.
REQ-012 rd_valid_o  output  1  window column available.
REQ-013 rd_ready_i  input  1  consumer takes column when rd_valid_o & rd_ready_i.
REQ-014 rd_data_o  output  WIN_ROWS*DATA_W  lane i (bits i*DATA_W upward) = mem[row_off+i][col].
REQ-015 rd_col_o  output  $clog2(MAP_W)  column index of current beat.
REQ-016 rd_last_o  output  1  high with rd_valid_o on final beat of final window.

Function
REQ-017 Two states, FILL and DRAIN; FILL entered from reset and clear.
REQ-018 FILL: wr_ready_o=1, rd_valid_o=0; each accepted pixel written to mem[wr_row][wr_col], wr_col increments, wraps at MAP_W-1 to 0 and increments wr_row.
REQ-019 Acceptance of pixel (MAP_H-1, MAP_W-1) SHALL move state to DRAIN on the same edge; rd_valid_o high the following cycle.
REQ-020 DRAIN: wr_ready_o=0, rd_valid_o=1; writes ignored, memory unchanged.
REQ-021 rd_data_o, rd_col_o, rd_last_o SHALL be stable while rd_valid_o & !rd_ready_i.
REQ-022 Each read handshake advances col; at col=MAP_W-1 col wraps to 0 and row_off increases by STRIDE.
REQ-023 Window count NWIN = floor((MAP_H-WIN_ROWS)/STRIDE)+1; no row index SHALL exceed MAP_H-1 (no modulo wrap); trailing partial windows are not emitted.
REQ-024 Handshake on beat with rd_last_o=1 SHALL return state to FILL, zero all counters; wr_ready_o high next cycle.
REQ-025 Total read beats per map SHALL equal NWIN*MAP_W (defaults: 4 windows, row_off 0,2,4,6, 48 beats).
REQ-026 clear_i SHALL take priority over any handshake in the same cycle: state FILL, counters zero, memory contents retained but unreadable.
REQ-027 Memory SHALL NOT be reset; only control state resets.

Reset
REQ-028 rstn_i low SHALL immediately force state FILL, wr/rd counters and row_off to 0, wr_ready_o=1, rd_valid_o=0, rd_last_o=0, rd_col_o=0.
REQ-029 Reset asserted mid-FILL or mid-DRAIN SHALL discard progress; next accepted pixel after release is written to (0,0).

Configuration
REQ-030 Macro FMAP_BUF_ERR_EN, when defined, SHALL add output err_o (1 bit), reset 0, set sticky on wr_valid_i high in DRAIN or rd_ready_i high in FILL, cleared only by rstn_i or clear_i.
REQ-031 Without FMAP_BUF_ERR_EN, err_o SHALL not exist and such events SHALL be silently ignored.

Verification
REQ-032 Defaults, write pixels 0..143 back-to-back, rd_ready_i=1 -> rd_valid_o rises cycle after 144th write; 48 beats; beat 0 lanes = 0,12,24,36,48,60; beat 47 lanes = 83,95,107,119,131,143 with rd_last_o=1.
REQ-033 Same fill, rd_ready_i toggled 1/0 every cycle -> rd_data_o held during stalls, beat sequence identical to REQ-032.
REQ-034 Assert clear_i at beat 20 of DRAIN -> wr_ready_o=1 next cycle; refill with 1000+k -> first beat lanes 1000,1012,...,1060.
REQ-035 rstn_i pulsed low after 70 writes -> outputs at reset values asynchronously; 144 fresh writes then drain correctly.
REQ-036 MAP_W=5, MAP_H=7, WIN_ROWS=3, STRIDE=3 -> NWIN=2, row_off 0,3, 10 beats, row 6 never emitted.
REQ-037 With FMAP_BUF_ERR_EN, wr_valid_i=1 during DRAIN -> err_o=1 next cycle, held until clear_i; memory contents unchanged.
